// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate vector sequencer.
//   - state_e   : sequencer FSM states
//   - *_B       : bit positions of each gate inside gate_out
//   - NUM_VEC   : number of (a,b) input combinations applied per run
//   - EXP_TABLE : expected gate_out for each vector index (a,b) = 00, 01, 10, 11
//   - CNT_W     : width of the dwell counter (covers DWELL up to 65535)
package gate_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned NOT_B  = 6;
  localparam int unsigned NAND_B = 5;
  localparam int unsigned NOR_B  = 4;
  localparam int unsigned AND_B  = 3;
  localparam int unsigned OR_B   = 2;
  localparam int unsigned XOR_B  = 1;
  localparam int unsigned XNOR_B = 0;

  localparam int unsigned NUM_VEC = 4;
  localparam int unsigned CNT_W   = 16;

  // Packed so element [i] is the expected value for vector i ("not" observes a).
  localparam logic [NUM_VEC-1:0][6:0] EXP_TABLE = {7'h0D, 7'h26, 7'h66, 7'h71};

endpackage

// File: rtl/dwell_timer.sv
// Per-vector cycle counter for the gate vector sequencer.
// Parameters: DWELL (cycles per vector), SETTLE (cycles before sampling).
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_clr       synchronous clear to 0 (start of a run)
//   i_en        count enable (sequencer in RUN)
//   o_at_settle strobe: this edge is the sample edge of the current vector
//   o_at_end    strobe: this edge ends the current vector's dwell
module dwell_timer
  import gate_seq_pkg::*;
#(
  parameter int unsigned DWELL  = 100,
  parameter int unsigned SETTLE = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_at_settle,
  output logic o_at_end
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  // r_cnt holds k during cycle k of a vector, so the edge closing cycle SETTLE-1
  // lies SETTLE cycles after the vector was applied.
  assign o_at_end    = i_en && (r_cnt == CNT_W'(DWELL - 1));
  assign o_at_settle = i_en && (r_cnt == CNT_W'(SETTLE - 1));

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clr) begin
      w_cnt_d = '0;
    end else if (i_en) begin
      w_cnt_d = o_at_end ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Clocked stimulus/response checker for the not/nand/nor/and/or/xor/xnor gate set.
// Applies (a,b) = 00, 01, 10, 11 for DWELL cycles each, samples gate_out SETTLE
// cycles into every vector, and reports a pass/fail verdict.
// Optional feature macro: GATE_SEQ_ERR_LOG_EN adds first-failure logging ports.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               begin a run (ignored while busy)
//   i_gate_out[6:0]       observed gate outputs: not,nand,nor,and,or,xor,xnor
//   o_a, o_b              registered stimulus
//   o_busy, o_done        run in progress / verdict held
//   o_pass                all four vectors matched (valid while done)
//   o_fail_mask[3:0]      bit i set when vector i mismatched
//   o_err_count[2:0]      number of mismatching vectors
//   o_first_fail_vec[1:0] earliest mismatching vector (GATE_SEQ_ERR_LOG_EN only)
//   o_first_fail_obs[6:0] gate_out seen at that vector (GATE_SEQ_ERR_LOG_EN only)
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned DWELL  = 100,
  parameter int unsigned SETTLE = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [6:0] i_gate_out,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_mask,
  output logic [2:0] o_err_count
`ifdef GATE_SEQ_ERR_LOG_EN
  ,
  output logic [1:0] o_first_fail_vec,
  output logic [6:0] o_first_fail_obs
`endif
);

  if (DWELL < 2 || DWELL > 65535 || SETTLE < 1 || SETTLE > DWELL - 1) begin : g_param_check
    $error("gate_vector_sequencer: need 2 <= DWELL <= 65535 and 1 <= SETTLE <= DWELL-1");
  end

  state_e     r_state, w_state_d;
  logic [1:0] r_vec, w_vec_d;
  logic       r_a, w_a_d;
  logic       r_b, w_b_d;
  logic       r_pass, w_pass_d;
  logic [3:0] r_fail_mask, w_fail_mask_d;
  logic [2:0] r_err_count, w_err_count_d;
`ifdef GATE_SEQ_ERR_LOG_EN
  logic [1:0] r_ffv, w_ffv_d;
  logic [6:0] r_ffo, w_ffo_d;
`endif

  logic w_clr;
  logic w_run;
  logic w_at_settle;
  logic w_at_end;
  logic w_mismatch;

  assign w_run = (r_state == StRun);

  dwell_timer #(
    .DWELL (DWELL),
    .SETTLE(SETTLE)
  ) u_dwell_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_clr),
    .i_en       (w_run),
    .o_at_settle(w_at_settle),
    .o_at_end   (w_at_end)
  );

  // Case inequality so an X/Z bit on gate_out is flagged in simulation.
  assign w_mismatch = (i_gate_out !== EXP_TABLE[r_vec]);

  always_comb begin
    w_state_d     = r_state;
    w_vec_d       = r_vec;
    w_a_d         = r_a;
    w_b_d         = r_b;
    w_pass_d      = r_pass;
    w_fail_mask_d = r_fail_mask;
    w_err_count_d = r_err_count;
    w_clr         = 1'b0;
`ifdef GATE_SEQ_ERR_LOG_EN
    w_ffv_d       = r_ffv;
    w_ffo_d       = r_ffo;
`endif
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d     = StRun;
          w_vec_d       = 2'd0;
          w_a_d         = 1'b0;
          w_b_d         = 1'b0;
          w_pass_d      = 1'b0;
          w_fail_mask_d = '0;
          w_err_count_d = '0;
          w_clr         = 1'b1;
`ifdef GATE_SEQ_ERR_LOG_EN
          w_ffv_d       = '0;
          w_ffo_d       = '0;
`endif
        end
      end
      StRun: begin
        if (w_at_settle && w_mismatch) begin
          w_fail_mask_d[r_vec] = 1'b1;
          w_err_count_d        = r_err_count + 3'd1;
`ifdef GATE_SEQ_ERR_LOG_EN
          if (r_err_count == '0) begin
            w_ffv_d = r_vec;
            w_ffo_d = i_gate_out;
          end
`endif
        end
        if (w_at_end) begin
          if (r_vec == 2'(NUM_VEC - 1)) begin
            w_state_d = StDone;
            w_a_d     = 1'b0;
            w_b_d     = 1'b0;
            w_pass_d  = (w_err_count_d == '0);
          end else begin
            w_vec_d = r_vec + 2'd1;
            w_a_d   = w_vec_d[1];
            w_b_d   = w_vec_d[0];
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_vec       <= 2'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= '0;
      r_err_count <= '0;
`ifdef GATE_SEQ_ERR_LOG_EN
      r_ffv       <= '0;
      r_ffo       <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_vec       <= w_vec_d;
      r_a         <= w_a_d;
      r_b         <= w_b_d;
      r_pass      <= w_pass_d;
      r_fail_mask <= w_fail_mask_d;
      r_err_count <= w_err_count_d;
`ifdef GATE_SEQ_ERR_LOG_EN
      r_ffv       <= w_ffv_d;
      r_ffo       <= w_ffo_d;
`endif
    end
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_busy      = w_run;
  assign o_done      = (r_state == StDone);
  assign o_pass      = r_pass;
  assign o_fail_mask = r_fail_mask;
  assign o_err_count = r_err_count;
`ifdef GATE_SEQ_ERR_LOG_EN
  assign o_first_fail_vec = r_ffv;
  assign o_first_fail_obs = r_ffo;
`endif

endmodule
